// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type and constants for the instruction-fetch stage
package fetch_pkg;
  localparam int DEFAULT_XLEN = 64;
  localparam int DEFAULT_ILEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {FETCH_IDLE, FETCH_REQ, FETCH_WAIT, FETCH_DRAIN} fetch_state_e;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response bus between fetch and imem
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter int ILEN = DEFAULT_ILEN
);
  logic            req_valid;
  logic [XLEN-1:0] addr;
  logic            req_ready;
  logic            resp_valid;
  logic [ILEN-1:0] resp_data;
  logic            resp_err;
  modport master (output req_valid, addr, input req_ready, resp_valid, resp_data, resp_err);
  modport slave (input req_valid, addr, output req_ready, resp_valid, resp_data, resp_err);
endinterface

// File: rtl/fetch.sv
// fetch: one imem transaction per PC, delivering instruction plus commit metadata
module fetch
  import fetch_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter int ILEN = DEFAULT_ILEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] select_pc_i_pc,
  input  logic            select_pc_i_valid,
  input  logic            ctrl_i_flush,
  fetch_if.master         imem,
  output logic [ILEN-1:0] fetch_o_instr,
  output logic            fetch_o_commit,
  output logic [XLEN-1:0] fetch_o_commit_pc,
  output logic [ILEN-1:0] fetch_o_commit_instr,
  output logic [XLEN-1:0] fetch_o_commit_pre_pc,
  output logic            fetch_o_exc,
  output logic            fetch_o_busy
);
  fetch_state_e state, state_n;
  logic [XLEN-1:0] pc_q;
  logic accept, mis_accept, deliver, bad;
  assign accept = state == FETCH_IDLE && select_pc_i_valid && !ctrl_i_flush;
  assign mis_accept = accept && select_pc_i_pc[1:0] != 2'b00;
  assign deliver = state == FETCH_WAIT && imem.resp_valid && !ctrl_i_flush;
  assign bad = mis_accept || imem.resp_err;
  assign imem.req_valid = state == FETCH_REQ;
  assign imem.addr = pc_q;
  assign fetch_o_busy = state != FETCH_IDLE;
  assign fetch_o_commit_instr = fetch_o_instr;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_IDLE;
    else state <= state_n;
  end
  // next state: a flush in WAIT alongside the response discards it and returns to IDLE
  always_comb begin
    state_n = state;
    case (state)
      FETCH_IDLE:  state_n = accept && !mis_accept ? FETCH_REQ : FETCH_IDLE;
      FETCH_REQ:   state_n = ctrl_i_flush ? (imem.req_ready ? FETCH_DRAIN : FETCH_IDLE)
                                          : (imem.req_ready ? FETCH_WAIT : FETCH_REQ);
      FETCH_WAIT:  state_n = imem.resp_valid ? FETCH_IDLE : ctrl_i_flush ? FETCH_DRAIN : FETCH_WAIT;
      FETCH_DRAIN: state_n = imem.resp_valid ? FETCH_IDLE : FETCH_DRAIN;
      default:     state_n = FETCH_IDLE;
    endcase
  end
  // latched PC and registered delivery outputs; last-PC moves only on commit
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q                  <= '0;
      fetch_o_instr         <= '0;
      fetch_o_commit        <= 1'b0;
      fetch_o_commit_pc     <= '0;
      fetch_o_commit_pre_pc <= '0;
      fetch_o_exc           <= 1'b0;
    end else begin
      fetch_o_commit <= 1'b0;
      if (accept) pc_q <= select_pc_i_pc;
      if (mis_accept || deliver) begin
        fetch_o_commit        <= 1'b1;
        fetch_o_commit_pc     <= mis_accept ? select_pc_i_pc : pc_q;
        fetch_o_commit_pre_pc <= fetch_o_commit_pc;
        fetch_o_exc           <= bad;
        fetch_o_instr         <= bad ? ILEN'(NOP) : imem.resp_data;
      end
    end
  end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: randomized transaction-level checking of the fetch stage
module tb_fetch;
  import fetch_pkg::*;
  typedef struct {
    int          cyc;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc;
    logic [63:0] pre;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] select_pc_i_pc = '0;
  logic        select_pc_i_valid = 1'b0;
  logic        ctrl_i_flush = 1'b0;
  logic [31:0] fetch_o_instr, fetch_o_commit_instr;
  logic        fetch_o_commit, fetch_o_exc, fetch_o_busy;
  logic [63:0] fetch_o_commit_pc, fetch_o_commit_pre_pc;

  fetch_if imem ();

  fetch dut (
    .clk                  (clk),
    .rst                  (rst),
    .select_pc_i_pc       (select_pc_i_pc),
    .select_pc_i_valid    (select_pc_i_valid),
    .ctrl_i_flush         (ctrl_i_flush),
    .imem                 (imem),
    .fetch_o_instr        (fetch_o_instr),
    .fetch_o_commit       (fetch_o_commit),
    .fetch_o_commit_pc    (fetch_o_commit_pc),
    .fetch_o_commit_instr (fetch_o_commit_instr),
    .fetch_o_commit_pre_pc(fetch_o_commit_pre_pc),
    .fetch_o_exc          (fetch_o_exc),
    .fetch_o_busy         (fetch_o_busy)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 0;
  exp_t        q[$];
  logic [63:0] last_pc = '0;
  logic [31:0] held = '0;
  int          busy_lo = 1, busy_hi = 0, req_lo = 1, req_hi = 0;
  logic [63:0] req_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    logic ec, rv;
    exp_t e;
    if (chk_en) begin
      ec = q.size() != 0 && q[0].cyc == cyc;
      check("commit", fetch_o_commit, ec);
      if (ec) begin
        e = q.pop_front();
        held = e.instr;
        check("commit_pc", fetch_o_commit_pc, e.pc);
        check("commit_pre_pc", fetch_o_commit_pre_pc, e.pre);
        check("exc", fetch_o_exc, e.exc);
        check("commit_instr", fetch_o_commit_instr, e.instr);
      end
      check("instr_held", fetch_o_instr, held);
      check("busy", fetch_o_busy, cyc >= busy_lo && cyc <= busy_hi);
      rv = cyc >= req_lo && cyc <= req_hi;
      check("req_valid", imem.req_valid, rv);
      if (rv) check("req_addr", imem.addr, req_addr);
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      select_pc_i_valid = 1'b0;
      ctrl_i_flush = 1'($urandom_range(0, 1));
      imem.req_ready = 1'($urandom_range(0, 1));
      imem.resp_valid = 1'($urandom_range(0, 1));
      imem.resp_data = $urandom;
      imem.resp_err = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    ctrl_i_flush = 1'b0;
    imem.resp_valid = 1'b0;
  endtask

  // mode: 0 normal, 1 flush in REQ with ready low, 2 flush with ready,
  // 3 flush in WAIT before the response (f < w), 4 flush coincident with the response
  task automatic fetch_one(input logic [63:0] pc, input int d, input int w,
                           input logic [31:0] data, input logic err, input int mode, input int f);
    int a, h, r, e;
    exp_t x;
    a = cyc + 1;
    if (pc[1:0] != 2'b00) begin
      x = '{a, pc, NOP, 1'b1, last_pc};
      q.push_back(x);
      last_pc = pc;
      select_pc_i_valid = 1'b1;
      select_pc_i_pc = pc;
      imem.resp_valid = 1'($urandom_range(0, 1));
      imem.req_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      select_pc_i_valid = 1'b0;
      imem.resp_valid = 1'b0;
      return;
    end
    h = a + 1 + d;
    r = h + 1 + w;
    e = (mode == 1) ? a + d + 1 : r;
    req_addr = pc; req_lo = a; req_hi = a + d;
    busy_lo = a; busy_hi = e - 1;
    if (mode == 0) begin
      x = '{r, pc, err ? NOP : data, err, last_pc};
      q.push_back(x);
      last_pc = pc;
    end
    for (int t = a - 1; t < e; t++) begin
      select_pc_i_valid = (t == a - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      select_pc_i_pc = (t == a - 1) ? pc : {$urandom, $urandom};
      imem.req_ready = (t >= a && t <= a + d) ? (t == a + d && mode != 1) : 1'($urandom_range(0, 1));
      imem.resp_valid = (t > a + d) ? (t == r - 1) : 1'($urandom_range(0, 1));
      imem.resp_data = (t == r - 1) ? data : $urandom;
      imem.resp_err = (t == r - 1) ? err : 1'($urandom_range(0, 1));
      ctrl_i_flush = ((mode == 1 || mode == 2) && t == a + d) || (mode == 3 && t == h + f) ||
                     (mode == 4 && t == r - 1) ||
                     (((mode == 2 && t >= h) || (mode == 3 && t > h + f)) && t < r - 1 &&
                      $urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
    select_pc_i_valid = 1'b0;
    ctrl_i_flush = 1'b0;
    imem.resp_valid = 1'b0;
  endtask

  initial begin
    int m, md, w, f;
    logic [63:0] pc;
    imem.req_ready = 1'b0;
    imem.resp_valid = 1'b0;
    imem.resp_data = '0;
    imem.resp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", fetch_o_busy, 0);
    check("reset_commit", fetch_o_commit, 0);
    check("reset_req_valid", imem.req_valid, 0);
    check("reset_instr", fetch_o_instr, 0);
    check("reset_pre_pc", fetch_o_commit_pre_pc, 0);
    chk_en = 1;

    fetch_one(64'h8000_0000, 0, 0, 32'h0010_0093, 1'b0, 0, 0);
    check("aligned_commit", fetch_o_commit, 1);
    check("aligned_instr", fetch_o_instr, 64'h0010_0093);
    check("aligned_pc", fetch_o_commit_pc, 64'h8000_0000);
    check("aligned_pre_pc", fetch_o_commit_pre_pc, 0);
    check("aligned_exc", fetch_o_exc, 0);
    fetch_one(64'h8000_0004, 0, 0, 32'h0020_0113, 1'b0, 0, 0);
    check("b2b_pre_pc", fetch_o_commit_pre_pc, 64'h8000_0000);
    check("b2b_busy", fetch_o_busy, 0);
    fetch_one(64'h8000_0008, 4, 0, 32'h0030_0193, 1'b0, 0, 0);
    check("bp_commit", fetch_o_commit, 1);
    check("bp_instr", fetch_o_instr, 64'h0030_0193);
    fetch_one(64'h8000_0002, 0, 0, 32'h0, 1'b0, 0, 0);
    check("mis_commit", fetch_o_commit, 1);
    check("mis_instr", fetch_o_instr, 64'h0000_0013);
    check("mis_exc", fetch_o_exc, 1);
    check("mis_pre_pc", fetch_o_commit_pre_pc, 64'h8000_0008);
    fetch_one(64'h8000_000C, 0, 1, 32'hFFFF_FFFF, 1'b1, 0, 0);
    check("err_instr", fetch_o_instr, 64'h0000_0013);
    check("err_exc", fetch_o_exc, 1);

    fetch_one(64'h8000_0010, 0, 3, 32'h1111_1111, 1'b0, 3, 1);
    check("flush_wait_busy", fetch_o_busy, 0);
    check("flush_wait_commit", fetch_o_commit, 0);
    fetch_one(64'h8000_0014, 2, 2, 32'h2222_2222, 1'b0, 2, 0);
    fetch_one(64'h8000_0018, 3, 0, 32'h3333_3333, 1'b0, 1, 0);
    fetch_one(64'h8000_001C, 1, 2, 32'h4444_4444, 1'b0, 4, 0);
    check("flush_commit_pc", fetch_o_commit_pc, 64'h8000_000C);
    busy_lo = 1; busy_hi = 0; req_lo = 1; req_hi = 0;
    select_pc_i_valid = 1'b1;
    select_pc_i_pc = 64'h8000_0020;
    ctrl_i_flush = 1'b1;
    @(posedge clk); #1;
    select_pc_i_valid = 1'b0;
    ctrl_i_flush = 1'b0;
    check("idle_flush_busy", fetch_o_busy, 0);

    for (int i = 0; i < 150; i++) begin
      pc = {32'h0, 32'h8000_0000 | ($urandom_range(0, 1023) << 2)};
      if ($urandom_range(0, 5) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      m = $urandom_range(0, 7);
      md = m > 4 ? 0 : m;
      w = $urandom_range(0, 3);
      if (md == 3 && w == 0) w = 1;
      f = md == 3 ? $urandom_range(0, w - 1) : 0;
      fetch_one(pc, $urandom_range(0, 3), w, $urandom, 1'($urandom_range(0, 3) == 0), md, f);
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(1);
    chk_en = 0;
    select_pc_i_valid = 1'b1;
    select_pc_i_pc = 64'h8000_0040;
    @(posedge clk); #1;
    select_pc_i_valid = 1'b0;
    imem.req_ready = 1'b1;
    @(posedge clk); #1;
    imem.req_ready = 1'b0;
    check("pre_reset_busy", fetch_o_busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy", fetch_o_busy, 0);
    check("rst_commit", fetch_o_commit, 0);
    check("rst_instr", fetch_o_instr, 0);
    check("rst_commit_pc", fetch_o_commit_pc, 0);
    check("rst_pre_pc", fetch_o_commit_pre_pc, 0);
    check("rst_exc", fetch_o_exc, 0);
    check("rst_req_valid", imem.req_valid, 0);
    imem.resp_valid = 1'b1;
    imem.resp_data = 32'h0050_0293;
    @(posedge clk); #1;
    imem.resp_valid = 1'b0;
    check("stale_commit", fetch_o_commit, 0);
    check("stale_busy", fetch_o_busy, 0);
    check("stale_instr", fetch_o_instr, 0);
    q.delete();
    held = '0;
    last_pc = '0;
    busy_lo = 1; busy_hi = 0; req_lo = 1; req_hi = 0;
    chk_en = 1;
    fetch_one(64'h8000_0100, 1, 1, 32'h0060_0313, 1'b0, 0, 0);
    check("post_rst_pre_pc", fetch_o_commit_pre_pc, 0);
    check("post_rst_instr", fetch_o_instr, 64'h0060_0313);
    idle_cycles(2);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage. Takes the next PC from the PC-select stage, performs one instruction-memory transaction per PC over a valid/ready request and valid-only response interface, and presents the fetched instruction plus commit metadata to the fetch/decode pipeline register. It handles misaligned PCs, bus errors and pipeline flushes. It raises `fetch_o_busy` so PC selection holds its PC until the current fetch completes.

## Interface
- `XLEN`, 64, address/PC width
- `ILEN`, 32, instruction width
- `NOP`, 32'h0000_0013, instruction substituted on error or misalignment
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `select_pc_i_pc`  in  XLEN  PC to fetch
- `select_pc_i_valid`  in  1  `select_pc_i_pc` is valid this cycle
- `ctrl_i_flush`  in  1  abandon any in-flight fetch
- `imem_o_req_valid`  out  1  request valid
- `imem_o_addr`  out  XLEN  request address
- `imem_i_req_ready`  in  1  memory accepts request
- `imem_i_resp_valid`  in  1  response valid, one-cycle pulse
- `imem_i_resp_data`  in  ILEN  response instruction
- `imem_i_resp_err`  in  1  response bus error
- `fetch_o_instr`  out  ILEN  delivered instruction; held until next delivery
- `fetch_o_commit`  out  1  one-cycle pulse per delivered instruction
- `fetch_o_commit_pc`  out  XLEN  PC of delivered instruction
- `fetch_o_commit_instr`  out  ILEN  equals `fetch_o_instr` when committed
- `fetch_o_commit_pre_pc`  out  XLEN  PC of previous committed instruction; 0 after reset
- `fetch_o_exc`  out  1  delivered instruction carries misalign or bus error; qualified by commit
- `fetch_o_busy`  out  1  high whenever state is not IDLE

## Operation
- States are IDLE, REQ, WAIT and DRAIN. Every output and internal register resets to 0, and the state resets to IDLE.
- **IDLE:**
  - If `select_pc_i_valid` is high and `ctrl_i_flush` is low, latch the PC.
  - If the latched PC is aligned (`pc[1:0]==0`), go to REQ.
  - If it is misaligned, issue no request. Next cycle, deliver `NOP` with `fetch_o_exc=1` and stay IDLE.
  - `imem_i_resp_valid` is ignored in IDLE.
- **REQ:**
  - `imem_o_req_valid=1` and `imem_o_addr` = latched PC; both are held stable until `imem_i_req_ready`.
  - On ready, go to WAIT.
  - On flush with ready low, go to IDLE.
  - On flush with ready high, the request counts as accepted; go to DRAIN.
- **WAIT:**
  - When `imem_i_resp_valid` is high, register `imem_i_resp_data` and go to IDLE.
  - If `imem_i_resp_err` is set, substitute `NOP` and set exc.
  - On flush, go to DRAIN. If flush and response arrive in the same cycle, flush wins, the response is discarded, and the next state is IDLE.
- **DRAIN:**
  - Discard exactly one response, then go to IDLE. No commit.
  - A further flush while in DRAIN keeps the state DRAIN.
- **Delivery:**
  - `fetch_o_commit` pulses the cycle after the response (or after the misaligned accept).
  - `fetch_o_commit_pc` = latched PC.
  - `fetch_o_commit_pre_pc` = the previous `fetch_o_commit_pc`; the last-PC register updates only on commit.
  - Flushed fetches never commit.
- **Upstream:** `select_pc_i_valid` while busy is ignored. Upstream holds its PC while `fetch_o_busy` is high.
- **Reset mid-operation:** returns to IDLE immediately. A stale response arriving afterwards is ignored because it lands in IDLE.

## Timing
- The memory never returns a response in the same cycle as the request handshake. `imem_i_resp_valid` in REQ is ignored.
- Best-case latency:
  - Cycle 0: valid accepted in IDLE.
  - Cycle 1: request valid with ready.
  - Cycle 2: response.
  - Cycle 3: `fetch_o_commit` high.
- Each additional ready-low cycle or response wait adds one cycle.
- Misaligned PC: valid at cycle 0, commit with exc at cycle 1.
- `fetch_o_busy` is combinational from state. All `fetch_o_*` data outputs are registered.
- Throughput is at most one instruction per 3 cycles. There is no outstanding-request overlap.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (`FETCH_IDLE`, `FETCH_REQ`, `FETCH_WAIT`, `FETCH_DRAIN`);
  - the `NOP` constant;
  - the `XLEN`/`ILEN` defaults.
- A single module; no sub-module is warranted.

## Test plan
- **Aligned fetch:** pc=0x8000_0000 valid, ready immediately, resp data=0x0010_0093 two cycles later. Required: commit at cycle 3 with instr=0x0010_0093, commit_pc=0x8000_0000, pre_pc=0, exc=0.
- **Back-to-back:** fetch 0x8000_0000 then 0x8000_0004. Required: second commit has pre_pc=0x8000_0000, and busy is high exactly between accept and commit.
- **Backpressure:** ready low 4 cycles. Required: addr stable for 5 cycles and commit at cycle 7.
- **Misaligned:** pc=0x8000_0002. Required: no `imem_o_req_valid`; commit next cycle with instr=0x0000_0013, exc=1.
- **Bus error:** resp_err=1 with data=0xFFFF_FFFF. Required: instr=0x0000_0013, exc=1.
- **Flush and reset:**
  - Flush in WAIT, then response. Required: no commit, state back to IDLE after the drained response.
  - Flush coincident with ready. Required: DRAIN.
  - rst during WAIT. Required: all outputs 0, and the late response is ignored.
